// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and sizing helpers for fifo_write_arbiter
package fifo_arb_pkg;

  localparam int ARB_N_REQ     = 4;
  localparam int ARB_BURST_LEN = 4;

  function automatic int cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  localparam int OWNER_W = $clog2(ARB_N_REQ);
  localparam int CNT_W   = cnt_w(ARB_BURST_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - rr_pick: rotating priority encoder, scans last_owner+1 upward modulo N_REQ
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ,
  parameter int OWN_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OWN_W-1:0] last_owner,
  output logic [OWN_W-1:0] winner,
  output logic             valid
);

  logic [OWN_W-1:0] idx;

  // Walk from the farthest offset down so the nearest requester after last_owner wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = OWN_W'((int'(last_owner) + k) % N_REQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among N_REQ producers
// Optional FIFO_ARB_PRIO0_EN: requester 0 wins every arbitration it requests; the others rotate among themselves.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = ARB_N_REQ,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int LVL_W     = 4,
  parameter int BURST_LEN = ARB_BURST_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  input  logic [LVL_W-1:0]          fifo_level,
  input  logic                      fifo_full,
  output logic                      fifo_write,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int OWN_W  = $clog2(N_REQ);
  localparam int BEAT_W = cnt_w(BURST_LEN);

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [OWN_W-1:0]  last_owner;
  logic [N_REQ-1:0]  rr_req;
  logic [OWN_W-1:0]  pick, winner;
  logic              pick_valid, win_valid;
  logic              owner_req, room, accept, burst_end;

`ifdef FIFO_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
  assign rr_req    = {req[N_REQ-1:1], 1'b0};
  assign winner    = req[0] ? '0 : pick;
  assign win_valid = req[0] | pick_valid;
`else
  localparam bit PRIO0 = 1'b0;
  assign rr_req    = req;
  assign winner    = pick;
  assign win_valid = pick_valid;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .OWN_W (OWN_W)
  ) u_rr_pick (
    .req        (rr_req),
    .last_owner (last_owner),
    .winner     (pick),
    .valid      (pick_valid)
  );

  // A write already in flight occupies the last free slot before fifo_level reflects it.
  assign owner_req = req[grant_id];
  assign room      = !fifo_full && !(fifo_write && (fifo_level == LVL_W'(DEPTH - 1)));
  assign busy      = (state == XFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack       = '0;
    accept    = 1'b0;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) state_nxt = XFER;
      end
      XFER: begin
        accept = owner_req && room;
        if (accept) ack[grant_id] = 1'b1;
        burst_end = !owner_req || (accept && (beat_cnt == BEAT_W'(BURST_LEN - 1)));
        if (burst_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With priority enabled, last_owner tracks only the rotating group so requester 0 cannot reset its rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_write <= 1'b0;
      fifo_data  <= '0;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_owner <= OWN_W'(N_REQ - 1);
    end else begin
      fifo_write <= accept;
      if (accept) begin
        fifo_data <= req_data[grant_id*DATA_W +: DATA_W];
        beat_cnt  <= beat_cnt + 1'b1;
      end
      if (state == IDLE && win_valid) begin
        grant_id <= winner;
        beat_cnt <= '0;
      end
      if (burst_end) begin
        beat_cnt <= '0;
        if (!PRIO0 || grant_id != '0) last_owner <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed scoreboard bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic [LW-1:0]   fifo_level;
  logic            fifo_full;
  logic            fifo_write;
  logic [DW-1:0]   fifo_data;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_write_arbiter #(
    .N_REQ (N), .DATA_W (DW), .DEPTH (8), .LVL_W (LW), .BURST_LEN (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_level (fifo_level),
    .fifo_full  (fifo_full),
    .fifo_write (fifo_write),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int          remaining [N];
  int          sent      [N];
  int          exp_seq   [N];
  logic [DW-1:0] base    [N];
  logic [DW-1:0] exp_q   [$];

  localparam bit [3:0] P2_ACK  [9] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0};
  localparam bit       P2_BUSY [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = (remaining[i] > 0);
      req_data[i*DW +: DW] = base[i] + DW'(sent[i]);
    end
  endtask

  task automatic push_words(input int o, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(base[o] + DW'(exp_seq[o]));
      exp_seq[o]++;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0;
      sent[i]      = 0;
      exp_seq[i]   = 0;
      base[i]      = '0;
    end
    exp_q.delete();
  endtask

  // One clock: drive producers, sample and score at the falling edge, retire acked words after the rising edge.
  task automatic tick(input logic [N-1:0] exp_ack, input logic exp_busy, input bit chk, input string tag);
    logic [N-1:0] ack_s;
    drive();
    @(negedge clk);
    ack_s = ack;
    if (chk) begin
      check({tag, "_ack"}, DW'(ack), DW'(exp_ack));
      check({tag, "_busy"}, DW'(busy), DW'(exp_busy));
      if (exp_ack != '0) check({tag, "_grant"}, DW'(grant_id), DW'(oh_idx(exp_ack)));
    end
    if (fifo_write) begin
      if (exp_q.size() == 0) check("unexpected_write", DW'(fifo_write), '0);
      else check("wdata", fifo_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_s[i]) begin
        sent[i]++;
        remaining[i]--;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive();
      @(negedge clk);
      check({tag, "_ack"},   DW'(ack),        '0);
      check({tag, "_write"}, DW'(fifo_write), '0);
      check({tag, "_data"},  fifo_data,       '0);
      check({tag, "_grant"}, DW'(grant_id),   '0);
      check({tag, "_busy"},  DW'(busy),       '0);
      @(posedge clk);
      #1;
    end
    clear_model();
    drive();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    fifo_level = '0;
    fifo_full  = 1'b0;
    clear_model();

    // Reset with every requester asking.
    for (int i = 0; i < N; i++) remaining[i] = 1;
    do_reset("t1_rst");

    // Single requester, six words: burst of four, gap, burst of two.
    base[2] = 32'hA0;
    remaining[2] = 6;
    push_words(2, 6);
    for (int t = 0; t < 9; t++) tick(P2_ACK[t], P2_BUSY[t], 1'b1, "t2");
    tick('0, 1'b0, 1'b0, "t2_drain");
    check("t2_drained", DW'(exp_q.size()), '0);

    // All requesting: owners 0,1,2,3,0 with a gap before each grant.
    do_reset("t3_rst");
    for (int i = 0; i < N; i++) begin
      base[i] = DW'((i + 1) * 32'h100);
      remaining[i] = 100;
    end
    for (int g = 0; g < 5; g++) begin
      push_words(g % N, 4);
      tick('0, 1'b0, 1'b1, "t3_gap");
      for (int b = 0; b < 4; b++) tick(N'(1 << (g % N)), 1'b1, 1'b1, "t3_beat");
    end
    for (int i = 0; i < N; i++) remaining[i] = 0;
    tick('0, 1'b0, 1'b1, "t3_end");
    check("t3_drained", DW'(exp_q.size()), '0);

    // Back-pressure: in-flight write at level DEPTH-1, then fifo_full stall.
    base[1] = 32'hC0;
    remaining[1] = 8;
    push_words(1, 8);
    fifo_level = 4'd7;
    tick('0, 1'b0, 1'b1, "t4_idle");
    tick(4'h2, 1'b1, 1'b1, "t4_first");
    tick('0, 1'b1, 1'b1, "t4_inflight");
    fifo_level = '0;
    tick(4'h2, 1'b1, 1'b1, "t4_room");
    fifo_full = 1'b1;
    for (int t = 0; t < 3; t++) tick('0, 1'b1, 1'b1, "t4_full");
    fifo_full = 1'b0;
    tick(4'h2, 1'b1, 1'b1, "t4_resume");
    for (int t = 0; t < 12; t++) tick('0, 1'b0, 1'b0, "t4_run");
    check("t4_drained", DW'(exp_q.size()), '0);
    check("t4_all_acked", DW'(remaining[1]), '0);

    // Reset during the second beat drops the in-flight write and restarts at requester 0.
    base[3] = 32'hD0;
    remaining[3] = 4;
    push_words(3, 4);
    tick('0, 1'b0, 1'b1, "t5_idle");
    tick(4'h8, 1'b1, 1'b1, "t5_beat1");
    drive();
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_write", DW'(fifo_write), '0);
    check("t5_async_ack",   DW'(ack),        '0);
    check("t5_async_busy",  DW'(busy),       '0);
    check("t5_async_data",  fifo_data,       '0);
    @(posedge clk);
    #1;
    do_reset("t5_rst");
    base[0] = 32'hE0;
    base[3] = 32'hF0;
    remaining[0] = 1;
    remaining[3] = 1;
    push_words(0, 1);
    push_words(3, 1);
    tick('0, 1'b0, 1'b1, "t5_idle2");
    tick(4'h1, 1'b1, 1'b1, "t5_restart");
    for (int t = 0; t < 6; t++) tick('0, 1'b0, 1'b0, "t5_run");
    check("t5_drained", DW'(exp_q.size()), '0);

    // Two persistent requesters: priority build keeps 0, plain build alternates.
    do_reset("t6_rst");
    base[0] = 32'h600;
    base[1] = 32'h700;
    remaining[0] = 100;
    remaining[1] = 100;
    for (int g = 0; g < 4; g++) begin
      int o;
`ifdef FIFO_ARB_PRIO0_EN
      o = 0;
`else
      o = g % 2;
`endif
      push_words(o, 4);
      tick('0, 1'b0, 1'b1, "t6_gap");
      for (int b = 0; b < 4; b++) tick(N'(1 << o), 1'b1, 1'b1, "t6_beat");
    end
    remaining[0] = 0;
    remaining[1] = 0;
    tick('0, 1'b0, 1'b1, "t6_end");
    check("t6_drained", DW'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
